// File: rtl/rca_pkg.sv
// Shared types and helpers for the byte-serial add/subtract engine.
// State encoding, byte width and index sizing.
package rca_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rca_seq_adder_if.sv
// Request/response handshake bundle for rca_seq_adder.
// slave = engine side, master = requester side.
interface rca_seq_adder_if
  import rca_pkg::*;
#(
  parameter int NBYTES = 4
);

  localparam int W = BYTE_W * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b,
    output in_cin, in_sub, out_ready,
    input  in_ready, out_valid,
    input  out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b,
    input  in_cin, in_sub, out_ready,
    output in_ready, out_valid,
    output out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/RCA_8.sv
// 8-bit ripple-carry adder slice.
// Pure combinational; one full adder per bit.
module RCA_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[8];
  end

endmodule

// File: rtl/rca_seq_adder.sv
// Byte-serial multi-precision add/subtract around one RCA_8.
// One byte pair per RUN cycle, LSB first, carry held in cy_q.
module rca_seq_adder
  import rca_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic          clk,
  input  logic          rst,
  rca_seq_adder_if.slave bus
);

  localparam int IDX_W = clog2(NBYTES);

  typedef logic [NBYTES-1:0][BYTE_W-1:0] bytes_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  bytes_t           a_q, a_d;
  bytes_t           b_q, b_d;
  bytes_t           res_q, res_d;
  bytes_t           sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             rdy_q;
  logic [7:0]       s_byte;
  logic             s_cout;
  logic             last;
  logic             fire;

  RCA_8 u_rca (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (cy_q),
    .sum  (s_byte),
    .cout (s_cout)
  );

  assign last = (idx_q == IDX_W'(NBYTES - 1));
  assign fire = bus.in_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          a_d     = bus.in_a;
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          cy_d    = bus.in_sub | bus.in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q] = s_byte;
        cy_d         = s_cout;
        idx_d        = idx_q + IDX_W'(1);
        if (last) begin
          // b_q already holds the effective (inverted) B
          sum_d   = res_d;
          cout_d  = s_cout;
          ovf_d   = (a_q[NBYTES-1][7] == b_q[NBYTES-1][7])
                 && (s_byte[7] != a_q[NBYTES-1][7]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      rdy_q   <= (state_d == IDLE);
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed self-checking bench for rca_seq_adder, NBYTES=4.
// Hand-computed vectors, latency, backpressure and reset.
module tb_rca_seq_adder;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rca_seq_adder_if #(.NBYTES(NB)) bus ();

  rca_seq_adder #(.NBYTES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        cin,
    input logic        sub
  );
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("wait_ready", 64'(bus.in_ready), 64'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_op(
    input string       tag,
    input logic [31:0] es,
    input logic        ec,
    input logic        eo
  );
    for (int k = 1; k < NB; k++) begin
      tick();
      chk({tag, "_busy"}, 64'(bus.out_valid), 64'd0);
    end
    tick();
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(bus.out_sum), 64'(es));
    chk({tag, "_cout"}, 64'(bus.out_cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(bus.out_ovf), 64'(eo));
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_op(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        cin,
    input logic        sub,
    input logic [31:0] es,
    input logic        ec,
    input logic        eo
  );
    start(a, b, cin, sub);
    finish_op(tag, es, ec, eo);
    drain(tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;

    tick();
    chk("rst_rdy", 64'(bus.in_ready), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_rdy", 64'(bus.in_ready), 64'd1);
    chk("idle_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_sum", 64'(bus.out_sum), 64'd0);
    chk("idle_cout", 64'(bus.out_cout), 64'd0);
    chk("idle_ovf", 64'(bus.out_ovf), 64'd0);

    run_op("add_ff", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
           32'h0000_0100, 1'b0, 1'b0);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
           32'h0000_0000, 1'b1, 1'b0);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
           32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op("sub_brw", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1,
           32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
           32'h8000_0000, 1'b0, 1'b1);
    run_op("add_mix", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
           32'h2345_678A, 1'b0, 1'b0);

    start(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    finish_op("bp", 32'h2345_6789, 1'b0, 1'b0);
    bus.in_a     = 32'hDEAD_BEEF;
    bus.in_b     = 32'h0BAD_F00D;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_sum", 64'(bus.out_sum), 64'h2345_6789);
      chk("bp_rdy", 64'(bus.in_ready), 64'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_sum", 64'(bus.out_sum), 64'd0);
    chk("mid_rst_rdy", 64'(bus.in_ready), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_rdy", 64'(bus.in_ready), 64'd1);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);

    run_op("recover", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1,
           32'h0000_0002, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
